// File: rtl/accel_ap_sequencer.sv
`timescale 1ns/1ps
// accel_ap_sequencer
//   Initiator side of the ap_ctrl_hs handshake for the parking-spot direction
//   accelerator. A periodic tick snapshots the sensor/route inputs, raises
//   ap_start until ap_ready, waits for ap_done and captures next_dirc.
//   Dropped ticks are counted and hung transactions are aborted by a watchdog.
//
// Ports
//   HCLK, HRESETn                    clock, asynchronous active-low reset
//   enable                           tick generator run enable
//   clear_status                     zeroes overrun_cnt and timeout_flag
//   accel_x_in..end_point_in         live sensor/route values
//   accel_x..end_point               snapshot values driven to accelerator
//   ap_start/ap_ready/ap_done/ap_idle  ap_ctrl_hs handshake (ap_idle unused)
//   next_dirc, next_dirc_ap_vld      accelerator result and its qualifier
//   dirc_out, dirc_valid             last captured direction, 1-cycle strobe
//   busy                             transaction in flight
//   overrun_cnt                      saturating count of dropped ticks
//   timeout_flag                     sticky watchdog abort flag
module accel_ap_sequencer #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TICK_CYCLES    = 200000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              enable,
  input  logic              clear_status,
  input  logic [DATA_W-1:0] accel_x_in,
  input  logic [DATA_W-1:0] yaw_in,
  input  logic [DATA_W-1:0] start_point_in,
  input  logic [DATA_W-1:0] end_point_in,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  output logic [DATA_W-1:0] accel_x,
  output logic [DATA_W-1:0] yaw,
  output logic [DATA_W-1:0] start_point,
  output logic [DATA_W-1:0] end_point,
  input  logic [DATA_W-1:0] next_dirc,
  input  logic              next_dirc_ap_vld,
  output logic [DATA_W-1:0] dirc_out,
  output logic              dirc_valid,
  output logic              busy,
  output logic [7:0]        overrun_cnt,
  output logic              timeout_flag
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                ap_start_q, ap_start_d;
  logic [DATA_W-1:0]   accel_x_q, accel_x_d, yaw_q, yaw_d;
  logic [DATA_W-1:0]   start_point_q, start_point_d, end_point_q, end_point_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                got_vld_q, got_vld_d;
  logic [DATA_W-1:0]   dirc_out_q, dirc_out_d;
  logic                dirc_valid_q, dirc_valid_d;
  logic [7:0]          overrun_cnt_q, overrun_cnt_d;
  logic                timeout_flag_q, timeout_flag_d;

  logic tick;
  logic done_now;
  logic unused_ap_idle;

  assign unused_ap_idle = ap_idle;
  assign tick     = enable && (tick_cnt_q == TICK_LAST);
  // In START completion needs ap_ready too; in WAIT_DONE ap_done alone suffices.
  assign done_now = ap_done && ((state_q != S_START) || ap_ready);

  always_comb begin
    state_d        = state_q;
    wd_cnt_d       = wd_cnt_q;
    ap_start_d     = ap_start_q;
    accel_x_d      = accel_x_q;
    yaw_d          = yaw_q;
    start_point_d  = start_point_q;
    end_point_d    = end_point_q;
    hold_d         = hold_q;
    got_vld_d      = got_vld_q;
    dirc_out_d     = dirc_out_q;
    dirc_valid_d   = 1'b0;
    overrun_cnt_d  = overrun_cnt_q;
    timeout_flag_d = timeout_flag_q;
    tick_cnt_d     = (!enable || tick) ? '0 : tick_cnt_q + TICK_W'(1);

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          accel_x_d     = accel_x_in;
          yaw_d         = yaw_in;
          start_point_d = start_point_in;
          end_point_d   = end_point_in;
          ap_start_d    = 1'b1;
          wd_cnt_d      = '0;
          got_vld_d     = 1'b0;
          state_d       = S_START;
        end
      end
      default: begin
        if (tick && (overrun_cnt_q != 8'hFF)) begin
          overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
        if (next_dirc_ap_vld) begin
          hold_d    = next_dirc;
          got_vld_d = 1'b1;
        end
        if (done_now) begin
          state_d    = S_IDLE;
          ap_start_d = 1'b0;
          got_vld_d  = 1'b0;
          // A qualifier in the completing cycle is newer than the held value.
          if (next_dirc_ap_vld || got_vld_q) begin
            dirc_out_d   = next_dirc_ap_vld ? next_dirc : hold_q;
            dirc_valid_d = 1'b1;
          end
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_flag_d = 1'b1;
          ap_start_d     = 1'b0;
          got_vld_d      = 1'b0;
          state_d        = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
          if ((state_q == S_START) && ap_ready) begin
            ap_start_d = 1'b0;
            state_d    = S_WAIT_DONE;
          end
        end
      end
    endcase

    if (clear_status) begin
      overrun_cnt_d  = '0;
      timeout_flag_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= '0;
      wd_cnt_q       <= '0;
      ap_start_q     <= 1'b0;
      accel_x_q      <= '0;
      yaw_q          <= '0;
      start_point_q  <= '0;
      end_point_q    <= '0;
      hold_q         <= '0;
      got_vld_q      <= 1'b0;
      dirc_out_q     <= '0;
      dirc_valid_q   <= 1'b0;
      overrun_cnt_q  <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      ap_start_q     <= ap_start_d;
      accel_x_q      <= accel_x_d;
      yaw_q          <= yaw_d;
      start_point_q  <= start_point_d;
      end_point_q    <= end_point_d;
      hold_q         <= hold_d;
      got_vld_q      <= got_vld_d;
      dirc_out_q     <= dirc_out_d;
      dirc_valid_q   <= dirc_valid_d;
      overrun_cnt_q  <= overrun_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign ap_start     = ap_start_q;
  assign accel_x      = accel_x_q;
  assign yaw          = yaw_q;
  assign start_point  = start_point_q;
  assign end_point    = end_point_q;
  assign dirc_out     = dirc_out_q;
  assign dirc_valid   = dirc_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun_cnt  = overrun_cnt_q;
  assign timeout_flag = timeout_flag_q;

endmodule
